csr_tohost_unit: RTL and testbench
==================================

// Module: csr_tohost_unit
// PURPOSE
//   Machine CSR unit in the CPU's execute/writeback boundary. Executes CSRRW/RS/RC(+I) ops
//   from the execute stage and holds the tohost register (0x51E) that the ISA bench polls:
//   tohost[0]=1 ends the test, tohost[31:1]==0 means pass, else it is the failing test number.
//   Also provides the 64-bit cycle/instret counters and a sticky test-status summary.
// PARAMETERS
//   RESET_TOHOST  32'h0  tohost value after reset
//   CNT_W         64     counter width; must be 33..64; the high word is bits [CNT_W-1:32], zero-extended
// PORTS
//   clk        in   1   core clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   csr_en     in   1   valid CSR op from execute this cycle
//   csr_op     in   2   01=RW, 10=RS (set), 11=RC (clear); 00 = no-op (treated as csr_en=0)
//   csr_addr   in   12  CSR address
//   csr_src    in   32  rs1 value or zero-extended uimm (execute already muxed it)
//   csr_rd_x0  in   1   rd==x0: suppresses the read side effect only, rvalid still pulses
//   flush      in   1   kill the op presented this cycle (branch mispredict/redirect)
//   retire     in   1   one instruction retired this cycle
//   csr_rvalid out  1   old CSR value is valid on csr_rdata (1 cycle after an accepted op)
//   csr_rdata  out  32  old (pre-write) CSR value, registered
//   illegal    out  1   1-cycle pulse with rvalid: unknown address or write to read-only CSR
//   tohost     out  32  current tohost register (the bench probes this)
//   done       out  1   sticky: tohost[0] has been written to 1 since reset
//   pass       out  1   sticky, valid when done: tohost[31:1]==0 at the completing write
//   done_cycle out  32  cycle[31:0] captured at the edge that set done
// BEHAVIOUR
//   - Reset: all outputs 0; tohost=RESET_TOHOST; cycle=instret=0. Reset mid-op drops the op, no rvalid.
//   - Accept: op accepted when csr_en & csr_op!=0 & !flush & !rst. Latency 1: rvalid/rdata/illegal
//     on the next cycle; the new value is visible to an op issued in the next cycle (no hazard).
//   - Write value: RW -> src; RS -> old|src; RC -> old&~src. RS/RC with src==0 performs no write.
//   - Map: 0x51E tohost RW; 0xC00 cycle, 0xC80 cycleh, 0xC02 instret, 0xC82 instreth read-only.
//     Any other address: rdata=0, illegal=1, no state change. Write to a read-only CSR
//     (RW, or RS/RC with src!=0): illegal=1, no write, rdata still the old value.
//   - cycle: +1 every non-reset cycle. instret: +1 on retire. Both wrap at 2^CNT_W with no flag.
//     A read returns the value before that edge's increment. A CSR op that is also retiring sees
//     instret without itself.
//   - done: set on the edge where an accepted tohost write produces bit0=1; pass=(new[31:1]==0);
//     done_cycle=cycle[31:0] at that edge. Later tohost writes update tohost only; done, pass
//     and done_cycle hold until reset.
//   - Flush together with csr_en: no write, no rvalid, no illegal. retire is independent of flush.
//   - Back-to-back ops: one accepted per cycle, no stall; ops 1 and 2 to the same CSR: op 2's
//     rdata = op 1's written value.
// STRUCTURE
//   - csr_pkg: CSR_TOHOST/CYCLE/CYCLEH/INSTRET/INSTRETH address localparams, CSR_OP_RW/RS/RC codes.
//   - Sub-module csr_counter64 (clk, rst, inc, q[CNT_W-1:0]), instantiated twice (cycle, instret).
//   - Read mux and write-value calculation are combinational; rdata/rvalid/illegal are registered.
// TESTING
//   1 Reset 30 cycles, then RW 0x51E src=1 -> next cycle rvalid=1, rdata=0; tohost=1, done=1, pass=1.
//   2 RW 0x51E src=0x0000_000B -> done=1, pass=0, tohost[31:1]=5; a later RW src=0 keeps done=1, pass=0.
//   3 RS 0x51E src=0x6, then RC src=0x2 -> rdata=0 then 0x6; tohost=0x4; done=0.
//   4 Hold retire=1 for 100 cycles after reset, then read 0xC02 and 0xC00 -> instret=100; the two
//     cycle reads differ by the issue gap.
//   5 Set cycle to 0xFFFF_FFFF via force -> next read of cycleh=1, cycle=0 (carry into high word).
//   6 csr_en+flush on RW 0x51E src=1 -> no rvalid, tohost unchanged; RW 0xC00 -> illegal=1, cycle
//     unchanged; addr 0x123 -> illegal=1, rdata=0.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op codes and write-value helper for the tohost CSR unit
package csr_pkg;

  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  // New CSR value produced by an op from the old value and the source operand
  function automatic logic [31:0] csr_wdata(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = src;
      CSR_OP_RS: res = old_val | src;
      CSR_OP_RC: res = old_val & ~src;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - wide free-running event counter with synchronous clear
module csr_counter64 #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wraps silently at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/csr_tohost_unit.sv
// rtl/csr_tohost_unit.sv - machine CSR unit holding tohost, cycle/instret and test status
module csr_tohost_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_TOHOST = 32'h0,
  parameter int          CNT_W        = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_src,
  input  logic        csr_rd_x0,
  input  logic        flush,
  input  logic        retire,
  output logic        csr_rvalid,
  output logic [31:0] csr_rdata,
  output logic        illegal,
  output logic [31:0] tohost,
  output logic        done,
  output logic        pass,
  output logic [31:0] done_cycle
);

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [31:0]      cycle_hi;
  logic [31:0]      instret_hi;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;
  logic [31:0] tohost_q, tohost_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [31:0] done_cycle_q, done_cycle_d;

  logic        accept;
  logic        known;
  logic        read_only;
  logic        wr_attempt;
  logic        tohost_we;
  logic [31:0] old_val;
  logic [31:0] wr_val;

  // None of these CSRs have read side effects, so rd==x0 changes nothing here
  logic unused_rd_x0;
  assign unused_rd_x0 = csr_rd_x0;

  csr_counter64 #(.CNT_W(CNT_W)) u_cycle (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .q   (cycle_cnt)
  );

  csr_counter64 #(.CNT_W(CNT_W)) u_instret (
    .clk (clk),
    .rst (rst),
    .inc (retire),
    .q   (instret_cnt)
  );

  assign cycle_hi   = 32'(cycle_cnt[CNT_W-1:32]);
  assign instret_hi = 32'(instret_cnt[CNT_W-1:32]);

  // Address decode, read mux and write-value/next-state calculation
  always_comb begin
    known     = 1'b1;
    read_only = 1'b1;
    old_val   = 32'h0;
    case (csr_addr)
      CSR_TOHOST: begin
        old_val   = tohost_q;
        read_only = 1'b0;
      end
      CSR_CYCLE:    old_val = cycle_cnt[31:0];
      CSR_CYCLEH:   old_val = cycle_hi;
      CSR_INSTRET:  old_val = instret_cnt[31:0];
      CSR_INSTRETH: old_val = instret_hi;
      default:      known   = 1'b0;
    endcase

    accept     = csr_en && (csr_op != CSR_OP_NONE) && !flush && !rst;
    // RS/RC with a zero mask are pure reads and never count as writes
    wr_attempt = (csr_op == CSR_OP_RW) || (csr_src != 32'h0);
    wr_val     = csr_wdata(csr_op, old_val, csr_src);
    tohost_we  = accept && known && !read_only && wr_attempt;

    rvalid_d  = accept;
    rdata_d   = accept ? old_val : rdata_q;
    illegal_d = accept && (!known || (read_only && wr_attempt));
    tohost_d  = tohost_we ? wr_val : tohost_q;

    done_d       = done_q;
    pass_d       = pass_q;
    done_cycle_d = done_cycle_q;
    // Only the first completing write is recorded; later ones just move tohost
    if (tohost_we && wr_val[0] && !done_q) begin
      done_d       = 1'b1;
      pass_d       = (wr_val[31:1] == 31'h0);
      done_cycle_d = cycle_cnt[31:0];
    end
  end

  // Response and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
      illegal_q    <= 1'b0;
      tohost_q     <= RESET_TOHOST;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      done_cycle_q <= 32'h0;
    end else begin
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      illegal_q    <= illegal_d;
      tohost_q     <= tohost_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      done_cycle_q <= done_cycle_d;
    end
  end

  assign csr_rvalid = rvalid_q;
  assign csr_rdata  = rdata_q;
  assign illegal    = illegal_q;
  assign tohost     = tohost_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign done_cycle = done_cycle_q;

endmodule

// File: tb/tb_csr_tohost_unit.sv
// tb/tb_csr_tohost_unit.sv - scoreboard bench for csr_tohost_unit
module tb_csr_tohost_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic        csr_rd_x0;
  logic        flush;
  logic        retire;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic [31:0] tohost;
  logic        done;
  logic        pass;
  logic [31:0] done_cycle;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  csr_tohost_unit dut (
    .clk        (clk),
    .rst        (rst),
    .csr_en     (csr_en),
    .csr_op     (csr_op),
    .csr_addr   (csr_addr),
    .csr_src    (csr_src),
    .csr_rd_x0  (csr_rd_x0),
    .flush      (flush),
    .retire     (retire),
    .csr_rvalid (csr_rvalid),
    .csr_rdata  (csr_rdata),
    .illegal    (illegal),
    .tohost     (tohost),
    .done       (done),
    .pass       (pass),
    .done_cycle (done_cycle)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endfunction

  // Monitor: pops one expectation per response, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (csr_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected rvalid: rdata 0x%08h, expected no response", csr_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " rdata"}, csr_rdata, e.rdata);
        check({e.name, " illegal"}, {31'h0, illegal}, {31'h0, e.ill});
      end
    end else if (illegal) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray illegal: got 1 without rvalid, expected 0");
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    csr_en = 1'b0;
    flush = 1'b0;
    retire = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one op for one cycle starting at a negedge; pushes the expected response if accepted
  task automatic issue(input string nm, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] src, input logic fl, input logic acc,
                       input logic [31:0] exp_rd, input logic exp_ill);
    exp_t e;
    csr_en = 1'b1;
    csr_op = op;
    csr_addr = addr;
    csr_src = src;
    flush = fl;
    if (acc) begin
      e.name = nm;
      e.rdata = exp_rd;
      e.ill = exp_ill;
      sb.push_back(e);
    end
    @(negedge clk);
    csr_en = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    csr_op = 2'b00;
    csr_addr = 12'h0;
    csr_src = 32'h0;
    csr_rd_x0 = 1'b0;
    @(negedge clk);

    // 1: reset state, then tohost=1 completes with pass
    do_reset(30);
    check("reset rvalid", {31'h0, csr_rvalid}, 32'h0);
    check("reset rdata", csr_rdata, 32'h0);
    check("reset tohost", tohost, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset pass", {31'h0, pass}, 32'h0);
    check("reset done_cycle", done_cycle, 32'h0);
    repeat (3) @(negedge clk);
    issue("t1 rw tohost", 2'b01, 12'h51E, 32'h1, 1'b0, 1'b1, 32'h0, 1'b0);
    check("t1 tohost", tohost, 32'h1);
    check("t1 done", {31'h0, done}, 32'h1);
    check("t1 pass", {31'h0, pass}, 32'h1);
    check("t1 done_cycle", done_cycle, 32'd3);

    // 2: failing test number 5, then sticky status survives a clearing write
    do_reset(2);
    issue("t2 rw 0xB", 2'b01, 12'h51E, 32'hB, 1'b0, 1'b1, 32'h0, 1'b0);
    check("t2 done", {31'h0, done}, 32'h1);
    check("t2 pass", {31'h0, pass}, 32'h0);
    check("t2 test number", {1'b0, tohost[31:1]}, 32'd5);
    issue("t2 rw 0", 2'b01, 12'h51E, 32'h0, 1'b0, 1'b1, 32'hB, 1'b0);
    check("t2 tohost after clear", tohost, 32'h0);
    check("t2 done sticky", {31'h0, done}, 32'h1);
    check("t2 pass sticky", {31'h0, pass}, 32'h0);

    // 3: set/clear back to back, zero-mask set is a pure read
    do_reset(2);
    issue("t3 rs 6", 2'b10, 12'h51E, 32'h6, 1'b0, 1'b1, 32'h0, 1'b0);
    issue("t3 rc 2", 2'b11, 12'h51E, 32'h2, 1'b0, 1'b1, 32'h6, 1'b0);
    issue("t3 rs 0", 2'b10, 12'h51E, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    check("t3 tohost", tohost, 32'h4);
    check("t3 done", {31'h0, done}, 32'h0);

    // 6: flush, read-only writes and unknown addresses (cycle is 3 here)
    issue("t6 flushed", 2'b01, 12'h51E, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("t6 tohost after flush", tohost, 32'h4);
    check("t6 done after flush", {31'h0, done}, 32'h0);
    issue("t6 rw cycle", 2'b01, 12'hC00, 32'h5, 1'b0, 1'b1, 32'd4, 1'b1);
    issue("t6 cycle after rw", 2'b10, 12'hC00, 32'h0, 1'b0, 1'b1, 32'd5, 1'b0);
    issue("t6 rc instret", 2'b11, 12'hC02, 32'h1, 1'b0, 1'b1, 32'h0, 1'b1);
    issue("t6 unknown read", 2'b10, 12'h123, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    issue("t6 unknown write", 2'b01, 12'h123, 32'hFF, 1'b0, 1'b1, 32'h0, 1'b1);
    issue("t6 op none", 2'b00, 12'h51E, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("t6 tohost final", tohost, 32'h4);

    // 4: 100 retirements, cycle reads separated by a known gap
    do_reset(2);
    retire = 1'b1;
    repeat (100) @(negedge clk);
    retire = 1'b0;
    issue("t4 cycle a", 2'b10, 12'hC00, 32'h0, 1'b0, 1'b1, 32'd100, 1'b0);
    issue("t4 instret", 2'b10, 12'hC02, 32'h0, 1'b0, 1'b1, 32'd100, 1'b0);
    repeat (2) @(negedge clk);
    issue("t4 cycle b", 2'b10, 12'hC00, 32'h0, 1'b0, 1'b1, 32'd104, 1'b0);
    retire = 1'b1;
    issue("t4 instret retiring", 2'b10, 12'hC02, 32'h0, 1'b0, 1'b1, 32'd100, 1'b0);
    retire = 1'b0;
    issue("t4 instret after", 2'b10, 12'hC02, 32'h0, 1'b0, 1'b1, 32'd101, 1'b0);
    issue("t4 instreth", 2'b10, 12'hC82, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

    // 5: carry from cycle low word into cycleh
    do_reset(2);
    force dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_cycle.cnt_q;
    @(negedge clk);
    issue("t5 cycle", 2'b10, 12'hC00, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    issue("t5 cycleh", 2'b10, 12'hC80, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
